// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Accepts load/store requests from a processor into an in-order queue and
//   issues them to memory one at a time. Each request completes with a
//   one-cycle processor_resp pulse carrying load data and a timeout flag.
//
// Ports
//   clk, reset_n               clock; synchronous active-low reset
//   processor_req, store,      request handshake (accepted when req_ready)
//   addr, datatomem            store = 1 write, 0 load
//   req_ready                  queue has room
//   processor_resp, rd_data,   completion pulse; rd_data/error valid with it
//   error                      error = 1 means the memory access timed out
//   write_req, read_req,       memory request levels, held while in flight
//   addrout, wdata
//   datafrommem, mem_done      memory completion and read data
module mem_req_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              processor_req,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datatomem,
  output logic              req_ready,
  output logic              processor_resp,
  output logic [DATA_W-1:0] rd_data,
  output logic              error,
  output logic              write_req,
  output logic              read_req,
  output logic [ADDR_W-1:0] addrout,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] datafrommem,
  input  logic              mem_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Timer counts completed BUSY cycles; the TIMEOUT-th BUSY cycle ends the wait.
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic              st;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  req_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  req_t          head;
  req_t          in_req;
  logic          push;
  logic          pop;

  assign req_ready = (cnt != CW'(DEPTH));
  assign push      = processor_req && req_ready;
  assign head      = fifo_q[rd_ptr];
  assign in_req    = '{st: store, a: addr, d: datatomem};

  // Storage needs no reset: entries are only read when cnt says they are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= in_req;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] tmr_q;
  logic          done_hit;
  logic          tmo_hit;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt != '0) begin
          pop     = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // mem_done has priority, so a completion on the timeout edge is good.
        if (mem_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (tmr_q == TMAX) begin
          tmo_hit = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs are registered; processor_resp is high exactly while in RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      tmr_q          <= '0;
      processor_resp <= 1'b0;
      rd_data        <= '0;
      error          <= 1'b0;
      write_req      <= 1'b0;
      read_req       <= 1'b0;
      addrout        <= '0;
      wdata          <= '0;
    end else begin
      state_q        <= state_d;
      processor_resp <= (state_d == RESP);
      if (pop) begin
        addrout   <= head.a;
        wdata     <= head.d;
        write_req <= head.st;
        read_req  <= !head.st;
        tmr_q     <= '0;
      end
      if (state_q == BUSY) begin
        if (done_hit || tmo_hit) begin
          write_req <= 1'b0;
          read_req  <= 1'b0;
          error     <= tmo_hit;
          // read_req still marks the in-flight request as a load here.
          if (done_hit && read_req) rd_data <= datafrommem;
        end else begin
          tmr_q <= tmr_q + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl (DEPTH=4, TIMEOUT=8). Stimulus pushes the
// expected memory request and processor response into queues; a monitor pops
// and compares when the DUT raises a memory request or processor_resp.
// The memory model returns datafrommem = {2'b00, addrout} ^ 16'hBEFF.
module tb_mem_req_ctrl;
  localparam int DW = 16;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          processor_req = 1'b0;
  logic          store = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] datatomem = '0;
  logic [DW-1:0] datafrommem = '0;
  logic          mem_done = 1'b0;
  logic          req_ready, processor_resp, error, write_req, read_req;
  logic [DW-1:0] rd_data, wdata;
  logic [AW-1:0] addrout;

  always #5 clk = ~clk;

  mem_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .processor_req(processor_req), .store(store),
    .addr(addr), .datatomem(datatomem), .req_ready(req_ready),
    .processor_resp(processor_resp), .rd_data(rd_data), .error(error),
    .write_req(write_req), .read_req(read_req), .addrout(addrout), .wdata(wdata),
    .datafrommem(datafrommem), .mem_done(mem_done)
  );

  typedef struct {logic st; logic [AW-1:0] a; logic [DW-1:0] d;} mreq_t;
  typedef struct {logic [DW-1:0] rd; logic err;} resp_t;

  mreq_t exp_mem[$];
  resp_t exp_resp[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    saw_full = 1'b0;
  int    mem_delay = 0;   // BUSY cycle index on which mem_done is returned; -1 = never
  bit    mem_force = 1'b0;
  int    busy_cnt = 0;
  int    cur_len = 0, last_len = 0, onset_cnt = 0, resp_cnt = 0, last_resp_cyc = 0;
  logic  prev_act = 1'b0, prev_resp = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory model
  always @(negedge clk) begin
    if (mem_force) begin
      mem_done    = 1'b1;
      datafrommem = 16'hDEAD;
    end else if (reset_n && (read_req || write_req)) begin
      if (mem_delay >= 0 && busy_cnt == mem_delay) begin
        mem_done    = 1'b1;
        datafrommem = {2'b00, addrout} ^ 16'hBEFF;
      end else begin
        mem_done    = 1'b0;
        datafrommem = '0;
      end
      busy_cnt++;
    end else begin
      mem_done    = 1'b0;
      datafrommem = '0;
      busy_cnt    = 0;
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    logic  act;
    mreq_t em;
    resp_t er;
    if (mon_en && reset_n) begin
      act = read_req | write_req;
      if (!req_ready) saw_full = 1'b1;
      chk("mem_mutex", {31'b0, read_req & write_req}, 32'd0);
      if (act && !prev_act) begin
        onset_cnt++;
        cur_len = 0;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual addr=%0h required none", addrout);
        end else begin
          em = exp_mem.pop_front();
          chk("mem_write_req", {31'b0, write_req}, {31'b0, em.st});
          chk("mem_read_req", {31'b0, read_req}, {31'b0, !em.st});
          chk("mem_addr", {18'b0, addrout}, {18'b0, em.a});
          chk("mem_wdata", {16'b0, wdata}, {16'b0, em.d});
        end
        hold_a = addrout;
        hold_d = wdata;
      end
      if (act) begin
        cur_len++;
        chk("mem_addr_stable", {18'b0, addrout}, {18'b0, hold_a});
        chk("mem_wdata_stable", {16'b0, wdata}, {16'b0, hold_d});
      end
      if (!act && prev_act) last_len = cur_len;
      if (processor_resp) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        chk("resp_one_cycle", {31'b0, prev_resp}, 32'd0);
        if (exp_resp.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected actual rd=%0h err=%0b required none", rd_data, error);
        end else begin
          er = exp_resp.pop_front();
          chk("resp_rd_data", {16'b0, rd_data}, {16'b0, er.rd});
          chk("resp_error", {31'b0, error}, {31'b0, er.err});
        end
      end
      prev_act  = act;
      prev_resp = processor_resp;
    end else begin
      prev_act  = 1'b0;
      prev_resp = 1'b0;
    end
  end

  // Call right after a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] erd, input logic eerr, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    processor_req = 1'b1; store = st; addr = a; datatomem = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual req_ready=0 required 1");
      processor_req = 1'b0;
      return;
    end
    exp_mem.push_back('{st, a, d});
    exp_resp.push_back('{erd, eerr});
    acc_cyc = cyc;
    @(negedge clk);
    processor_req = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_resp.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_resp.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_resp"}, {31'b0, processor_resp}, 32'd0);
    chk({tag, "_read_req"}, {31'b0, read_req}, 32'd0);
    chk({tag, "_write_req"}, {31'b0, write_req}, 32'd0);
    chk({tag, "_rd_data"}, {16'b0, rd_data}, 32'd0);
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    chk({tag, "_addrout"}, {18'b0, addrout}, 32'd0);
    chk({tag, "_wdata"}, {16'b0, wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r0, o0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // Single load, done in first BUSY cycle: resp 3 cycles after the accept cycle.
    mem_delay = 0;
    send(1'b0, 14'h0010, 16'h0000, 16'hBEEF, 1'b0, k);
    drain("drain_load");
    chk("load_latency", last_resp_cyc - k, 32'd3);
    chk("load_req_len", last_len, 32'd1);

    // Store: rd_data keeps the previous load value.
    send(1'b1, 14'h3FFF, 16'h1234, 16'hBEEF, 1'b0, k);
    drain("drain_store");
    chk("store_req_len", last_len, 32'd1);

    // Back-to-back loads with a stalled memory (done on 6th BUSY cycle).
    mem_delay = 5;
    saw_full  = 1'b0;
    r0 = resp_cnt;
    send(1'b0, 14'h0100, 16'hA001, 16'hBFFF, 1'b0, k);
    send(1'b0, 14'h0200, 16'hA002, 16'hBCFF, 1'b0, k);
    send(1'b0, 14'h0300, 16'hA003, 16'hBDFF, 1'b0, k);
    send(1'b0, 14'h0400, 16'hA004, 16'hBAFF, 1'b0, k);
    send(1'b0, 14'h0500, 16'hA005, 16'hBBFF, 1'b0, k);
    drain("drain_b2b");
    chk("b2b_saw_full", {31'b0, saw_full}, 32'd1);
    chk("b2b_resp_count", resp_cnt - r0, 32'd5);
    chk("b2b_req_len", last_len, 32'd6);

    // Timeout: 8 BUSY cycles, error=1, rd_data unchanged; late mem_done ignored.
    mem_delay = -1;
    send(1'b0, 14'h0020, 16'h0000, 16'hBBFF, 1'b1, k);
    drain("drain_timeout");
    chk("timeout_req_len", last_len, 32'd8);
    r0 = resp_cnt;
    o0 = onset_cnt;
    mem_force = 1'b1;
    repeat (4) @(negedge clk);
    mem_force = 1'b0;
    repeat (5) @(negedge clk);
    chk("late_done_no_resp", resp_cnt - r0, 32'd0);
    chk("late_done_no_req", onset_cnt - o0, 32'd0);

    // Completion on the timeout edge counts as success.
    mem_delay = 7;
    send(1'b0, 14'h0030, 16'h0000, 16'hBECF, 1'b0, k);
    drain("drain_collide");
    chk("collide_req_len", last_len, 32'd8);

    // Reset mid-BUSY with two requests queued: everything is dropped.
    mem_delay = -1;
    send(1'b0, 14'h0040, 16'h0000, 16'h0000, 1'b0, k);
    send(1'b0, 14'h0050, 16'h0000, 16'h0000, 1'b0, k);
    send(1'b0, 14'h0060, 16'h0000, 16'h0000, 1'b0, k);
    chk("pre_reset_busy", {31'b0, read_req}, 32'd1);
    exp_mem.delete();
    exp_resp.delete();
    r0 = resp_cnt;
    o0 = onset_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_no_resp", resp_cnt - r0, 32'd0);
    chk("midreset_fifo_empty", onset_cnt - o0, 32'd0);
    chk("midreset_ready", {31'b0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
